// File: rtl/muxn_rr_reg_pkg.sv
`default_nettype none
// ============================================================================
// muxn_rr_reg_pkg : mode encodings and select-width helper for muxn_rr_reg
// Revision 1.0
// ============================================================================
package muxn_rr_reg_pkg;

   localparam logic MODE_RR    = 1'b0;
   localparam logic MODE_FIXED = 1'b1;

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/muxn_rr_reg_if.sv
`default_nettype none
// ============================================================================
// muxn_rr_reg_if : source/sink handshake bundle of the registered N:1 mux
// Revision 1.0
// ============================================================================
interface muxn_rr_reg_if
   import muxn_rr_reg_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 4,
   parameter int SELW     = sel_width(CHANNELS)
) ();

   logic [CHANNELS*WIDTH-1:0] in_data;
   logic [CHANNELS-1:0]       in_valid;
   logic [CHANNELS-1:0]       in_ready;
   logic                      mode;
   logic [SELW-1:0]           sel;
   logic [WIDTH-1:0]          out_data;
   logic [SELW-1:0]           out_chan;
   logic                      out_valid;
   logic                      out_ready;

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_chan, out_valid
   );

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_chan, out_valid
   );

endinterface
`default_nettype wire

// File: rtl/muxn_rr_reg_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : one-hot round-robin grant searching upward from ptr+1
// Revision 1.0
// ============================================================================
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   input  logic          enable_i,
   output logic [N-1:0]  gnt_o,
   output logic [PW-1:0] idx_o
);

   int w_best_dist;
   int w_best_idx;
   int w_dist;

   // Smallest circular distance past ptr wins; no index-by-variable needed.
   always_comb begin
      w_best_dist = N;
      w_best_idx  = 0;
      w_dist      = 0;
      for (int j = 0; j < N; j++) begin
         w_dist = (j + N - 1 - int'(ptr_i)) % N;
         if (req_i[j] && (w_dist < w_best_dist)) begin
            w_best_dist = w_dist;
            w_best_idx  = j;
         end
      end
   end

   always_comb begin
      gnt_o = '0;
      for (int j = 0; j < N; j++) begin
         gnt_o[j] = enable_i && (w_best_dist < N) && (w_best_idx == j);
      end
      idx_o = PW'(w_best_idx);
   end

endmodule
`default_nettype wire

// File: rtl/muxn_rr_reg.sv
`default_nettype none
// ============================================================================
// muxn_rr_reg : registered N:1 mux, round-robin or fixed select, valid/ready
// Revision 1.0
// ============================================================================
module muxn_rr_reg
   import muxn_rr_reg_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 4,
   parameter int SELW     = sel_width(CHANNELS)
) (
   input  logic               clk,
   input  logic               rst_n,
   muxn_rr_reg_if.slave       bus
);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic [0:0]          state_q, state_d;
   logic [WIDTH-1:0]    data_q,  data_d;
   logic [SELW-1:0]     chan_q,  chan_d;
   logic [SELW-1:0]     ptr_q,   ptr_d;

   logic [CHANNELS-1:0] w_rr_gnt;
   logic [SELW-1:0]     w_rr_idx;
   logic [CHANNELS-1:0] w_fix_gnt;
   logic [CHANNELS-1:0] w_gnt;
   logic [CHANNELS-1:0] w_ready;
   logic [WIDTH-1:0]    w_word;
   logic [SELW-1:0]     w_chan;
   logic                w_can_load;
   logic                w_xfer;
   logic                w_is_rr;

   assign w_is_rr = (bus.mode == MODE_RR);

   rr_arbiter #(
      .N  (CHANNELS),
      .PW (SELW)
   ) u_arb (
      .req_i    (bus.in_valid),
      .ptr_i    (ptr_q),
      .enable_i (w_is_rr),
      .gnt_o    (w_rr_gnt),
      .idx_o    (w_rr_idx)
   );

   // An out-of-range sel matches no channel, so no grant is made.
   for (genvar g = 0; g < CHANNELS; g++) begin : g_fixed
      assign w_fix_gnt[g] = bus.in_valid[g] && (bus.sel == SELW'(g));
   end

   assign w_gnt      = w_is_rr ? w_rr_gnt : w_fix_gnt;
   assign w_chan     = w_is_rr ? w_rr_idx : bus.sel;
   assign w_can_load = (state_q == ST_EMPTY) || bus.out_ready;
   assign w_ready    = w_gnt & {CHANNELS{w_can_load}};
   assign w_xfer     = |(bus.in_valid & w_ready);

   always_comb begin
      w_word = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         w_word = w_word | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{w_gnt[i]}});
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      chan_d  = chan_q;
      ptr_d   = ptr_q;
      if (w_xfer) begin
         state_d = ST_FULL;
         data_d  = w_word;
         chan_d  = w_chan;
         if (w_is_rr) begin
            ptr_d = w_chan;
         end
      end else if (bus.out_ready) begin
         state_d = ST_EMPTY;
      end
   end

   // ptr resets to the last channel so channel 0 wins the first arbitration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         data_q  <= '0;
         chan_q  <= '0;
         ptr_q   <= SELW'(CHANNELS - 1);
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         chan_q  <= chan_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus.in_ready  = w_ready;
   assign bus.out_data  = data_q;
   assign bus.out_chan  = chan_q;
   assign bus.out_valid = (state_q == ST_FULL);

endmodule
`default_nettype wire

// File: tb/tb_muxn_rr_reg.sv
`default_nettype none
// ============================================================================
// tb_muxn_rr_reg : self-checking bench for muxn_rr_reg (4-ch and 3-ch builds)
// Revision 1.0
// ============================================================================
module tb_muxn_rr_reg;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   muxn_rr_reg_if #(.WIDTH(4), .CHANNELS(4)) bus4 ();
   muxn_rr_reg_if #(.WIDTH(4), .CHANNELS(3)) bus3 ();

   muxn_rr_reg #(.WIDTH(4), .CHANNELS(4)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   muxn_rr_reg #(.WIDTH(4), .CHANNELS(3)) u_dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: reference arbiter/valid model for the 4-channel build.
   typedef struct packed {
      logic [1:0] chan;
      logic [3:0] data;
   } sb_t;

   sb_t        sb[$];
   logic [1:0] m_ptr;
   logic       m_valid;

   always @(negedge clk or negedge rst_n) begin
      logic [3:0] m_gnt;
      logic       m_can;
      logic       m_xfer;
      int         m_idx;
      sb_t        exp_e;
      if (!rst_n) begin
         m_ptr   = 2'd3;
         m_valid = 1'b0;
         sb.delete();
      end else begin
         m_gnt = 4'b0000;
         m_idx = 0;
         if (bus4.mode == 1'b0) begin
            for (int k = 1; k <= 4; k++) begin
               if (m_gnt == 4'b0000 && bus4.in_valid[(int'(m_ptr) + k) % 4]) begin
                  m_idx = (int'(m_ptr) + k) % 4;
                  m_gnt[m_idx] = 1'b1;
               end
            end
         end else if (bus4.in_valid[bus4.sel]) begin
            m_idx = int'(bus4.sel);
            m_gnt[m_idx] = 1'b1;
         end
         m_can  = !m_valid || bus4.out_ready;
         m_xfer = m_can && (m_gnt != 4'b0000);
         chk("sb_in_ready", 32'(bus4.in_ready), 32'(m_can ? m_gnt : 4'b0000));
         chk("sb_out_valid", 32'(bus4.out_valid), 32'(m_valid));
         if (m_valid && bus4.out_ready) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
               exp_e = sb.pop_front();
               chk("sb_out_data", 32'(bus4.out_data), 32'(exp_e.data));
               chk("sb_out_chan", 32'(bus4.out_chan), 32'(exp_e.chan));
            end
         end
         if (m_xfer) begin
            exp_e.chan = 2'(m_idx);
            exp_e.data = bus4.in_data[m_idx*4 +: 4];
            sb.push_back(exp_e);
            if (bus4.mode == 1'b0) m_ptr = 2'(m_idx);
         end
         m_valid = m_xfer ? 1'b1 : (bus4.out_ready ? 1'b0 : m_valid);
      end
   end

   typedef struct {
      logic [3:0] iv;
      logic       md;
      logic [1:0] sl;
      logic       ordy;
      logic [3:0] e_rdy;
      logic       e_ov;
      logic [1:0] e_ch;
      logic [3:0] e_dat;
   } vec_t;

   vec_t tbl[16];

   initial begin
      #60000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      logic [3:0] seq_dat[5];
      checks   = 0;
      failures = 0;

      // Fixed-mode, sparse, drain, wrap and single-channel cycles (state after 1st block)
      tbl[0]  = '{4'b1111, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1, 2'd3, 4'hD};
      tbl[1]  = '{4'b1111, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b1, 2'd2, 4'hC};
      tbl[2]  = '{4'b1111, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1, 2'd3, 4'hD};
      tbl[3]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd2, 4'hC};
      tbl[4]  = '{4'b1010, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd0, 4'hA};
      tbl[5]  = '{4'b1010, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd1, 4'hB};
      tbl[6]  = '{4'b1010, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd3, 4'hD};
      tbl[7]  = '{4'b1010, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd1, 4'hB};
      tbl[8]  = '{4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b1, 2'd3, 4'hD};
      tbl[9]  = '{4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd3, 4'hD};
      tbl[10] = '{4'b1001, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b0, 2'd3, 4'hD};
      tbl[11] = '{4'b1001, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd0, 4'hA};
      tbl[12] = '{4'b1001, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd0, 4'hA};
      tbl[13] = '{4'b1001, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd3, 4'hD};
      tbl[14] = '{4'b0001, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA};
      tbl[15] = '{4'b0001, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA};

      seq_dat[0] = 4'hA; seq_dat[1] = 4'hB; seq_dat[2] = 4'hC;
      seq_dat[3] = 4'hD; seq_dat[4] = 4'hA;

      rst_n          = 1'b0;
      bus4.in_data   = 16'hDCBA;
      bus4.in_valid  = 4'b1111;
      bus4.mode      = 1'b0;
      bus4.sel       = 2'd0;
      bus4.out_ready = 1'b1;
      bus3.in_data   = 12'h765;
      bus3.in_valid  = 3'b111;
      bus3.mode      = 1'b1;
      bus3.sel       = 2'd3;
      bus3.out_ready = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus4.out_valid), 32'd0);
      chk("rst_out_data",  32'(bus4.out_data),  32'd0);
      chk("rst_out_chan",  32'(bus4.out_chan),  32'd0);
      rst_n = 1'b1;

      // Round-robin over all-valid: A,B,C,D,A after one cycle of latency
      @(negedge clk);
      chk("rr_latency_valid", 32'(bus4.out_valid), 32'd0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("rr_seq_data", 32'(bus4.out_data), 32'(seq_dat[k]));
         chk("rr_seq_chan", 32'(bus4.out_chan), 32'(k % 4));
         chk("rr_seq_valid", 32'(bus4.out_valid), 32'd1);
      end

      // Backpressure for three cycles, then simultaneous drain and load
      @(posedge clk);
      #1 bus4.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_data",     32'(bus4.out_data), 32'hB);
         chk("bp_chan",     32'(bus4.out_chan), 32'd1);
         chk("bp_in_ready", 32'(bus4.in_ready), 32'b0000);
      end
      @(posedge clk);
      #1 bus4.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", 32'(bus4.in_ready), 32'b0100);
      @(negedge clk);
      chk("bp_release_data", 32'(bus4.out_data), 32'hC);
      chk("bp_release_chan", 32'(bus4.out_chan), 32'd2);

      for (int r = 0; r < 16; r++) begin
         @(posedge clk);
         #1;
         bus4.in_valid  = tbl[r].iv;
         bus4.mode      = tbl[r].md;
         bus4.sel       = tbl[r].sl;
         bus4.out_ready = tbl[r].ordy;
         @(negedge clk);
         chk($sformatf("tbl%0d_in_ready", r),  32'(bus4.in_ready),  32'(tbl[r].e_rdy));
         chk($sformatf("tbl%0d_out_valid", r), 32'(bus4.out_valid), 32'(tbl[r].e_ov));
         chk($sformatf("tbl%0d_out_chan", r),  32'(bus4.out_chan),  32'(tbl[r].e_ch));
         chk($sformatf("tbl%0d_out_data", r),  32'(bus4.out_data),  32'(tbl[r].e_dat));
      end

      // Async reset pulse mid-stream; channel 0 must win right after release
      @(posedge clk);
      #1;
      bus4.in_valid = 4'b1111;
      chk("arst_pre_valid", 32'(bus4.out_valid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(bus4.out_valid), 32'd0);
      chk("arst_out_data",  32'(bus4.out_data),  32'd0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("arst_first_grant", 32'(bus4.in_ready), 32'b0001);
      @(negedge clk);
      chk("arst_first_chan", 32'(bus4.out_chan), 32'd0);
      chk("arst_first_data", 32'(bus4.out_data), 32'hA);

      // Three-channel build: sel=3 is out of range
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("oor_in_ready",  32'(bus3.in_ready),  32'b000);
         chk("oor_out_valid", 32'(bus3.out_valid), 32'd0);
      end
      @(posedge clk);
      #1 bus3.sel = 2'd2;
      @(negedge clk);
      chk("sel2_in_ready", 32'(bus3.in_ready), 32'b100);
      @(negedge clk);
      chk("sel2_out_valid", 32'(bus3.out_valid), 32'd1);
      chk("sel2_out_chan",  32'(bus3.out_chan),  32'd2);
      chk("sel2_out_data",  32'(bus3.out_data),  32'h7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
